// File: rtl/circuit_sweep_pkg.sv
// Shared types and constants for the exhaustive 4-input circuit sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package circuit_sweep_pkg;

  localparam int VEC_W      = 4;
  localparam int TBL_W      = 16;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/circuit_sweep_cmp.sv
// Lowest-set-bit finder over the table/golden difference vector.
// Latency: combinational.
// Backpressure: none.
// Ports: i_diff  - table XOR golden, bit n set where vector n disagrees
//        o_any   - at least one bit set
//        o_idx   - index of the lowest set bit, 0 when none is set
module circuit_sweep_cmp
  import circuit_sweep_pkg::*;
(
  input  logic [TBL_W-1:0] i_diff,
  output logic             o_any,
  output logic [VEC_W-1:0] o_idx
);

  always_comb begin
    o_any = |i_diff;
    o_idx = '0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = TBL_W - 1; i >= 0; i--) begin
      if (i_diff[i]) begin
        o_idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// Sweeps all 16 input vectors of an external 4-input circuit, capturing F into a truth table.
// Latency: start at edge k -> done pulse in cycle k+1+16*(SETTLE_CYCLES+1).
// Backpressure: none; start ignored while busy, abort returns to IDLE on the next edge.
// Ports: clk/rst (sync, active-high), start, abort, vec_o {A,B,C,D}, f_i (circuit F),
//        expected_i (golden table), busy, done, table_o, mismatch, mismatch_idx.
// Option: CIRCUIT_SWEEP_COMPARE_EN enables the golden-table comparison; otherwise
//         mismatch/mismatch_idx are tied to 0 and expected_i is ignored.
module circuit_sweep_ctrl
  import circuit_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec_o,
  input  logic             f_i,
  input  logic [TBL_W-1:0] expected_i,
  output logic             busy,
  output logic             done,
  output logic [TBL_W-1:0] table_o,
  output logic             mismatch,
  output logic [VEC_W-1:0] mismatch_idx
);

  // Out-of-range settings are clamped into the legal window.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < SETTLE_MIN) ? SETTLE_MIN :
                              (SETTLE_CYCLES > SETTLE_MAX) ? SETTLE_MAX : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [VEC_W-1:0] IDX_LAST    = VEC_W'(TBL_W - 1);

  state_t           r_state;
  state_t           w_next;
  logic [VEC_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [TBL_W-1:0] r_table;
  logic             w_start_ok;

  assign w_start_ok = start && !abort;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)                     w_next = ST_IDLE;
        else if (r_cnt == SETTLE_LAST) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)                  w_next = ST_IDLE;
        else if (r_idx == IDX_LAST) w_next = ST_DONE;
        else                        w_next = ST_SETTLE;
      end
      ST_DONE: begin
        // abort is deliberately not looked at here: a completed sweep always reports.
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_table <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_table <= '0;
          end
        end
        ST_SETTLE: begin
          if (!abort) r_cnt <= r_cnt + 1'b1;
        end
        ST_CAPTURE: begin
          if (!abort) begin
            r_table[r_idx] <= f_i;
            r_cnt          <= '0;
            // idx stops at the last vector; it is never wrapped back to 0.
            if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // vec_o follows idx directly, so it also holds its last value while idle.
  assign vec_o   = r_idx;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign table_o = r_table;

`ifdef CIRCUIT_SWEEP_COMPARE_EN
  logic [TBL_W-1:0] w_diff;
  logic             w_any;
  logic [VEC_W-1:0] w_first;
  logic             r_mismatch;
  logic [VEC_W-1:0] r_mismatch_idx;

  assign w_diff = r_table ^ expected_i;

  circuit_sweep_cmp u_cmp (
    .i_diff (w_diff),
    .o_any  (w_any),
    .o_idx  (w_first)
  );

  // The final table bit is written on the CAPTURE->DONE edge, so the
  // comparison seen during DONE already covers all 16 vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mismatch     <= 1'b0;
      r_mismatch_idx <= '0;
    end else if (r_state == ST_DONE) begin
      r_mismatch     <= w_any;
      r_mismatch_idx <= w_first;
    end
  end

  assign mismatch     = r_mismatch;
  assign mismatch_idx = r_mismatch_idx;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^expected_i;
  assign mismatch          = 1'b0;
  assign mismatch_idx      = '0;
`endif

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Bench for circuit_sweep_ctrl: two instances (SETTLE_CYCLES=1 and 3) each driving a
// behavioural copy of F=~(A&B|C)&D, checked every cycle against a timeline model
// plus directed literal expectations.
module tb_circuit_sweep_ctrl;

`ifdef CIRCUIT_SWEEP_COMPARE_EN
  localparam bit CMP_ON = 1'b1;
`else
  localparam bit CMP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 0, abort1 = 0, f1, busy1, done1, mis1;
  logic [3:0]  vec1, mi1;
  logic [15:0] exp1 = 16'h0222, tbl1;
  logic        start3 = 0, abort3 = 0, f3, busy3, done3, mis3;
  logic [3:0]  vec3, mi3;
  logic [15:0] exp3 = 16'h0222, tbl3;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  function automatic logic circ(input logic [3:0] v);
    return ~((v[3] & v[2]) | v[1]) & v[0];
  endfunction

  assign f1 = circ(vec1);
  assign f3 = circ(vec3);

  circuit_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .vec_o(vec1), .f_i(f1),
    .expected_i(exp1), .busy(busy1), .done(done1), .table_o(tbl1), .mismatch(mis1),
    .mismatch_idx(mi1)
  );

  circuit_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .vec_o(vec3), .f_i(f3),
    .expected_i(exp3), .busy(busy3), .done(done3), .table_o(tbl3), .mismatch(mis3),
    .mismatch_idx(mi3)
  );

  // Timeline model: t counts cycles since the start was accepted (1-based).
  // With period p = SETTLE+1, vector n is presented over t = n*p+1 .. n*p+p and
  // captured at t = (n+1)*p; t = 16*p+1 is the single done cycle.
  typedef struct packed {
    logic        active;
    logic [15:0] t;
    logic [15:0] tbl;
    logic [3:0]  vec;
    logic        mis;
    logic [3:0]  midx;
  } mstate_t;

  mstate_t m1 = '0, m3 = '0;

  function automatic logic [3:0] first_diff(input logic [15:0] d);
    int k = 0;
    while (k < 16 && !d[k]) k++;
    return (k < 16) ? 4'(k) : 4'd0;
  endfunction

  function automatic mstate_t step(input mstate_t s, input int p, input logic r,
                                   input logic st, input logic ab, input logic [15:0] ex);
    mstate_t n = s;
    int      v;
    if (r) begin
      n = '0;
    end else if (!s.active) begin
      if (st && !ab) begin
        n.active = 1'b1;
        n.t      = 16'd1;
        n.tbl    = '0;
        n.vec    = '0;
      end
    end else if (int'(s.t) == 16 * p + 1) begin
      n.active = 1'b0;
      if (CMP_ON) begin
        n.mis  = (s.tbl != ex);
        n.midx = first_diff(s.tbl ^ ex);
      end
    end else if (ab) begin
      n.active = 1'b0;
    end else begin
      if (int'(s.t) % p == 0) n.tbl[int'(s.t) / p - 1] = circ(4'(int'(s.t) / p - 1));
      n.t = s.t + 16'd1;
      v   = (int'(n.t) - 1) / p;
      n.vec = (v > 15) ? 4'd15 : 4'(v);
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m1 <= step(m1, 2, rst, start1, abort1, exp1);
    m3 <= step(m3, 4, rst, start3, abort3, exp3);
  end

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("vec1",  16'(vec1),  16'(m1.vec));
      cmp("busy1", 16'(busy1), 16'(m1.active));
      cmp("done1", 16'(done1), 16'(m1.active && m1.t == 16'd33));
      cmp("tbl1",  tbl1,       m1.tbl);
      cmp("mis1",  16'(mis1),  16'(m1.mis));
      cmp("midx1", 16'(mi1),   16'(m1.midx));
      cmp("vec3",  16'(vec3),  16'(m3.vec));
      cmp("busy3", 16'(busy3), 16'(m3.active));
      cmp("done3", 16'(done3), 16'(m3.active && m3.t == 16'd65));
      cmp("tbl3",  tbl3,       m3.tbl);
      cmp("mis3",  16'(mis3),  16'(m3.mis));
      cmp("midx3", 16'(mi3),   16'(m3.midx));
    end
  end

  // Pulse start on dut1, return the cycle count to done (cycle after start = 1),
  // then step one cycle past done so mismatch reflects the finished sweep.
  task automatic sweep1(input logic [15:0] ex, input bit abort_at_done, output int cyc);
    exp1 = ex;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (abort_at_done) abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
  endtask

  task automatic wait_vec1(input logic [3:0] v);
    int n = 0;
    while (!(vec1 == v && busy1 === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    cmp("wait_vec1_timeout", 16'(n < 200), 16'd1);
  endtask

  initial begin
    int c, d1, d2, dcount;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst_vec",  16'(vec1),  16'd0);
    cmp("rst_busy", 16'(busy1), 16'd0);
    cmp("rst_done", 16'(done1), 16'd0);
    cmp("rst_tbl",  tbl1,       16'h0000);
    cmp("rst_mis",  16'(mis1),  16'd0);
    cmp("rst_midx", 16'(mi1),   16'd0);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Full sweep, golden table matches.
    sweep1(16'h0222, 1'b0, c);
    cmp("lat_s1",   16'(c),    16'd33);
    cmp("tbl_full", tbl1,      16'h0222);
    cmp("mis_eq",   16'(mis1), 16'd0);

    // Bit 0 differs; abort raised during DONE must not suppress the result.
    sweep1(16'h0223, 1'b1, c);
    cmp("lat_0223", 16'(c),    16'd33);
    cmp("mis_0223", 16'(mis1), 16'(CMP_ON));
    cmp("idx_0223", 16'(mi1),  16'd0);

    // Bit 5 differs.
    sweep1(16'h0202, 1'b0, c);
    cmp("mis_0202", 16'(mis1), 16'(CMP_ON));
    cmp("idx_0202", 16'(mi1),  CMP_ON ? 16'd5 : 16'd0);

    // Abort while vector 6 settles.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_vec1(4'd6);
    abort1 = 1'b1;
    @(negedge clk); abort1 = 1'b0;
    cmp("abort_busy", 16'(busy1), 16'd0);
    cmp("abort_tbl",  tbl1,       16'h0022);
    cmp("abort_vec",  16'(vec1),  16'd6);
    cmp("abort_mis",  16'(mis1),  16'(CMP_ON));
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 === 1'b1) dcount++;
    end
    cmp("abort_no_done", 16'(dcount), 16'd0);

    // Reset in the middle of a sweep, then a clean sweep.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    wait_vec1(4'd9);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cmp("mid_rst_vec",  16'(vec1),  16'd0);
    cmp("mid_rst_busy", 16'(busy1), 16'd0);
    cmp("mid_rst_done", 16'(done1), 16'd0);
    cmp("mid_rst_tbl",  tbl1,       16'h0000);
    cmp("mid_rst_mis",  16'(mis1),  16'd0);
    cmp("mid_rst_midx", 16'(mi1),   16'd0);
    sweep1(16'h0222, 1'b0, c);
    cmp("post_rst_lat", 16'(c), 16'd33);
    cmp("post_rst_tbl", tbl1,   16'h0222);

    // start together with abort in IDLE: abort wins.
    @(negedge clk); start1 = 1'b1; abort1 = 1'b1;
    @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
    cmp("start_abort_busy", 16'(busy1), 16'd0);

    // start held high: one sweep, the next begins only after returning to IDLE.
    @(negedge clk); start1 = 1'b1;
    @(negedge clk);
    c = 1; d1 = 0; d2 = 0;
    while (d2 == 0 && c < 200) begin
      if (done1 === 1'b1) begin
        if (d1 == 0) d1 = c;
        else         d2 = c;
      end
      if (d2 == 0) begin
        @(negedge clk);
        c++;
      end
    end
    start1 = 1'b0;
    cmp("held_done1", 16'(d1), 16'd33);
    cmp("held_done2", 16'(d2), 16'd67);
    repeat (3) @(negedge clk);
    cmp("held_idle", 16'(busy1), 16'd0);

    // SETTLE_CYCLES=3 instance.
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    c = 1;
    while (done3 !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    cmp("lat_s3", 16'(c), 16'd65);
    @(negedge clk);
    cmp("tbl_s3", tbl3, 16'h0222);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/circuit_sweep_ctrl.md
CIRCUIT_SWEEP_CTRL -- requirements
Module: circuit_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, which sets the cycles each input vector is held before F is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1 bit: cancels a sweep in progress.
REQ-006 SHALL have port vec_o, output, 4 bits: drives the combinational circuit as {A,B,C,D}, with A as the MSB.
REQ-007 SHALL have port f_i, input, 1 bit: the circuit output F.
REQ-008 SHALL have port expected_i, input, 16 bits: the golden truth table, where bit n is the expected F for vec n.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse when a sweep completes.
REQ-011 SHALL have port table_o, output, 16 bits: the captured truth table, where bit n is F sampled at vec n.
REQ-012 SHALL have port mismatch, output, 1 bit: comparison result (see Configuration).
REQ-013 SHALL have port mismatch_idx, output, 4 bits: the lowest vector index where table_o differs from expected_i.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, CAPTURE and DONE.
REQ-015 SHALL go IDLE->SETTLE when start=1 and abort=0, clearing idx and the settle count to 0; start outside IDLE SHALL be ignored.
REQ-016 SHALL hold vec_o=idx throughout SETTLE, and go SETTLE->CAPTURE after exactly SETTLE_CYCLES cycles in SETTLE.
REQ-017 SHALL, in CAPTURE, write table_o[idx] from f_i, then go to DONE if idx==15, else increment idx and return to SETTLE.
REQ-018 SHALL, in DONE, assert done for exactly one cycle, update mismatch and mismatch_idx, and go to IDLE.
REQ-019 SHALL meet this latency: start sampled at edge k gives done high in cycle k+1+16*(SETTLE_CYCLES+1), which is k+33 at the default.
REQ-020 SHALL NOT wrap idx past 15; a sweep always covers exactly vec 0..15, once each, in ascending order.
REQ-021 SHALL respond to abort=1 in SETTLE or CAPTURE by going to IDLE on the next edge: no capture that cycle, no done, table_o keeps its partial contents, mismatch unchanged.
REQ-022 SHALL give abort priority when start and abort are both 1 in IDLE: remain in IDLE.
REQ-023 SHALL ignore abort in DONE; done still pulses.
REQ-024 SHALL clear table_o to 0 when a new sweep starts; table_o, mismatch and mismatch_idx SHALL hold from DONE until the next start.
REQ-025 SHALL hold vec_o at its last driven value in IDLE.

Reset
REQ-026 SHALL, with rst=1 at an edge, force state=IDLE, idx=0, vec_o=0, table_o=0, busy=0, done=0, mismatch=0 and mismatch_idx=0, from any state including mid-sweep.
REQ-027 SHALL give rst priority over start and abort.

Configuration
REQ-028 SHALL, with macro CIRCUIT_SWEEP_COMPARE_EN defined, compute in DONE mismatch=(final table != expected_i) and mismatch_idx=the lowest differing bit index, or 0 if there is none.
REQ-029 SHALL, with CIRCUIT_SWEEP_COMPARE_EN undefined, keep the expected_i port but ignore it, and tie mismatch and mismatch_idx to 0.

Structure
REQ-030 SHALL place in package circuit_sweep_pkg: the state enum, VEC_W=4, TBL_W=16, and the SETTLE_CYCLES range limits.
REQ-031 SHALL implement the lowest-set-bit finder on (table XOR expected_i) as sub-module circuit_sweep_cmp, instantiated only under CIRCUIT_SWEEP_COMPARE_EN.
REQ-032 SHALL leave the circuit under test external, connected through vec_o and f_i.

Verification
REQ-033 SHALL cover a full sweep against the real circuit (F=~(A&B|C)&D) at SETTLE_CYCLES=1: pulse start -> done at start+33 cycles, table_o=16'h0222.
REQ-034 SHALL cover compare with the macro on: expected_i=16'h0222 -> mismatch=0; expected_i=16'h0223 -> mismatch=1, mismatch_idx=0; expected_i=16'h0202 -> mismatch=1, mismatch_idx=5.
REQ-035 SHALL cover abort at vec_o=6 in SETTLE -> IDLE on the next edge, done never high, table_o=16'h0022, busy=0.
REQ-036 SHALL cover reset mid-sweep at vec_o=9 -> all outputs 0 on the next edge; a following start gives a clean sweep, table_o=16'h0222.
REQ-037 SHALL cover start held high throughout the sweep -> a single sweep, with a second sweep starting only from IDLE after done.
REQ-038 SHALL cover SETTLE_CYCLES=3 -> each vec_o held 3 cycles, done at start+65 cycles.
